// File: rtl/sum_result_fifo.sv
// First-word-fall-through result FIFO behind the 16-bit adder; drops and flags results when full.
// Optional drop counter enabled by defining SUM_RESULT_FIFO_DROP_CNT_EN.
module sum_result_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   occ_t          state;
   logic          push;
   logic          pop;
   logic          drop;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state = PARTIAL;
      if (count == '0)
         state = EMPTY;
      else if (count == FULL_CNT)
         state = FULL;
   end

   assign out_valid = (state != EMPTY);
   assign out_data  = mem[rp];
   assign pop       = out_valid & out_ready;
   // A full FIFO still accepts a result when the head leaves on the same edge.
   assign push      = in_valid & ((state != FULL) | pop);
   assign drop      = in_valid & (state == FULL) & ~pop;

   always_ff @(posedge clk) begin
      if (push)
         mem[wp] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Set has priority over clear so a drop in the clearing cycle is not lost.
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= 8'd0;
      else if (drop)
         drop_cnt <= sat_inc8(drop_cnt);
   end
`endif

endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed testbench for sum_result_fifo (W=16, DEPTH=4).
module tb_sum_result_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [2:0]  count;
   logic        overflow;
   logic        clr_ovf = 1'b0;
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sum_result_fifo #(.W(16), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill4(input logic [15:0] base);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = base + 16'(i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: valid=%b count=%0d ovf=%b, want 0 0 0", out_valid, count, overflow);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: valid=%b count=%0d ovf=%b, want 0 0 0", out_valid, count, overflow);
         end
      end
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
      tests++;
      if (drop_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_dropcnt: got %0d want 0", drop_cnt);
      end
`endif
   endtask

   task automatic test_pass_through();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0123;
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h0123 || count !== 3'd1) begin
         fails++;
         $display("FAIL pass_first: valid=%b data=%h count=%0d, want 1 0123 1", out_valid, out_data, count);
      end
      tick();
      tests++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         fails++;
         $display("FAIL pass_drained: valid=%b count=%0d, want 0 0", out_valid, count);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_fill_order();
      fill4(16'h0001);
      tests++;
      if (count !== 3'd4 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL fill_count: count=%0d valid=%b, want 4 1", count, out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (out_data !== 16'h0001 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fill_hold: data=%h valid=%b, want 0001 1", out_data, out_valid);
         end
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tests++;
         if (out_data !== 16'(i) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fill_order: data=%h valid=%b, want %h 1", out_data, out_valid, 16'(i));
         end
         tick();
      end
      out_ready = 1'b0;
      tests++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL fill_empty: count=%0d valid=%b, want 0 0", count, out_valid);
      end
   endtask

   task automatic test_overflow();
      fill4(16'h0001);
      in_valid = 1'b1;
      in_data  = 16'h0055;
      tick();
      in_valid = 1'b0;
      tests++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         fails++;
         $display("FAIL ovf_set: ovf=%b count=%0d, want 1 4", overflow, count);
      end
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
      tests++;
      if (drop_cnt !== 8'd1) begin
         fails++;
         $display("FAIL ovf_dropcnt1: got %0d want 1", drop_cnt);
      end
`endif
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear: ovf=%b want 0", overflow);
      end
      // drop and clear in the same cycle: set must win
      in_valid = 1'b1;
      in_data  = 16'h0066;
      clr_ovf  = 1'b1;
      tick();
      in_valid = 1'b0;
      clr_ovf  = 1'b0;
      tests++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         fails++;
         $display("FAIL ovf_set_wins: ovf=%b count=%0d, want 1 4", overflow, count);
      end
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
      tests++;
      if (drop_cnt !== 8'd2) begin
         fails++;
         $display("FAIL ovf_dropcnt2: got %0d want 2", drop_cnt);
      end
`endif
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tests++;
         if (out_data !== 16'(i) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drain: data=%h valid=%b, want %h 1", out_data, out_valid, 16'(i));
         end
         tick();
      end
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         fails++;
         $display("FAIL ovf_empty: valid=%b count=%0d, want 0 0", out_valid, count);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
   endtask

   task automatic test_full_push_pop();
      fill4(16'h0001);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0005;
      tests++;
      if (out_data !== 16'h0001) begin
         fails++;
         $display("FAIL fpp_head: data=%h want 0001", out_data);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (overflow !== 1'b0 || count !== 3'd4 || out_data !== 16'h0002) begin
         fails++;
         $display("FAIL fpp_nodrop: ovf=%b count=%0d data=%h, want 0 4 0002", overflow, count, out_data);
      end
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         tests++;
         if (out_data !== 16'(i) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fpp_drain: data=%h valid=%b, want %h 1", out_data, out_valid, 16'(i));
         end
         tick();
      end
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         fails++;
         $display("FAIL fpp_empty: valid=%b count=%0d, want 0 0", out_valid, count);
      end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0B01;
      tick();
      in_data   = 16'h0B02;
      tick();
      in_valid  = 1'b0;
      tests++;
      if (count !== 3'd2) begin
         fails++;
         $display("FAIL mrst_pre: count=%0d want 2", count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         fails++;
         $display("FAIL mrst_async: valid=%b count=%0d, want 0 0", out_valid, count);
      end
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 16'h0AAA;
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h0AAA || count !== 3'd1) begin
         fails++;
         $display("FAIL mrst_first: valid=%b data=%h count=%0d, want 1 0aaa 1", out_valid, out_data, count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         fails++;
         $display("FAIL mrst_empty: valid=%b count=%0d, want 0 0", out_valid, count);
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_fill_order();
      test_overflow();
      test_full_push_pop();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sum_result_fifo.md
# sum_result_fifo

- Downstream consumer of the 16-bit adder stage; captures each single-cycle `valid`/`y` result pulse into a small first-word-fall-through FIFO.
- Re-presents results to the next stage over a `valid`/`ready` handshake, so a stalling consumer does not lose sums.
- The adder has no backpressure. Results arriving while the FIFO is full and not being drained are dropped and flagged.

## Interface
Parameters:
- `W`, 16, data width; matches the adder result width.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  one-cycle result strobe; driven by the adder's `valid`.
- `in_data`  input  W  result value; driven by the adder's `y`; sampled only when `in_valid` is 1.
- `out_valid`  output  1  head entry is available.
- `out_ready`  input  1  consumer accepts the head entry this cycle.
- `out_data`  output  W  head entry value; holds its value while `out_valid` is 1 and `out_ready` is 0.
- `count`  output  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.
- `overflow`  output  1  sticky flag; set when a result is dropped.
- `clr_ovf`  input  1  synchronous clear of `overflow`.
- `drop_cnt`  output  8  saturating count of dropped results; present only with `SUM_RESULT_FIFO_DROP_CNT_EN`.

## Operation
- Storage:
  - DEPTH×W register array.
  - Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Registered `count`.
- Occupancy state, derived from `count`:
  - EMPTY when `count`==0.
  - PARTIAL when 0<`count`<DEPTH.
  - FULL when `count`==DEPTH.
- Outputs derived from state:
  - `out_valid` = (state != EMPTY).
  - `out_data` = mem[`rp`]. When EMPTY, `out_data` is don't-care; the bench must not check it.
- Pop: `pop` = `out_valid` & `out_ready`. On pop, `rp` increments.
- Push: `push` = `in_valid` & (state != FULL or `pop`). On push, mem[`wp`] <= `in_data` and `wp` increments.
  - Push while FULL is accepted only when a pop happens in the same cycle (slot freed and reused on the same edge).
- Count update: `count` <= `count` + `push` − `pop`.
  - Simultaneous push and pop in PARTIAL leaves `count` unchanged.
- Drop: `drop` = `in_valid` & FULL & !`pop`.
  - Data is discarded; pointers and mem are unchanged.
  - `overflow` <= 1 on the next edge.
- `overflow` clear: `clr_ovf` clears `overflow` on the next edge.
  - If `clr_ovf` and `drop` occur in the same cycle, set wins and `overflow` stays 1.
- `out_ready` while EMPTY has no effect. Popping is impossible when EMPTY.
- Reset (asynchronous, at any time, including mid-burst): flushes all entries.
  - `wp`=`rp`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
  - mem contents are not reset.

## Timing
- Reset values:
  - `out_valid`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
  - `out_data`=mem[0] (don't-care).
- Latency: a result with `in_valid` sampled at edge k appears at the outputs after edge k, when the FIFO was empty.
  - `out_valid`=1 and `out_data`=`in_data` in the cycle following edge k.
  - Zero added bubble between the adder's `valid` cycle and this block's `out_valid` cycle.
- Throughput: one push and one pop per cycle sustained.
- Ordering: strict FIFO order, no reordering.
- Handshake: the consumer may hold `out_ready` low indefinitely. `out_valid` and `out_data` must stay stable until a pop.
- `overflow` rises one edge after the dropping cycle.

## Configuration
- `SUM_RESULT_FIFO_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` port, an 8-bit counter incremented on every `drop`, saturating at 255.
  - Cleared only by reset; `clr_ovf` does not affect it.
- Undefined: the `drop_cnt` port and its counter are absent. Only the sticky `overflow` flag reports drops.

## Test plan
All cases use W=16, DEPTH=4.
- Reset then idle: `rst_n` low 3 cycles then high, no `in_valid` → `out_valid`=0, `count`=0, `overflow`=0 throughout.
- Single pass-through: `in_valid`=1, `in_data`=0x0123 for one cycle, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=0x0123; the cycle after, `count`=0 and `out_valid`=0.
- Fill and order: `out_ready`=0, push 0x0001, 0x0002, 0x0003, 0x0004 → `count`=4; then `out_ready`=1 → `out_data` shows 1, 2, 3, 4 on consecutive cycles, and `count` returns to 0.
- Overflow: FIFO full with 1..4, `out_ready`=0, push 0x0055 → `overflow`=1 next cycle, `count`=4, and drained data is 1..4 with 0x0055 absent; with the macro, `drop_cnt`=1. Then pulse `clr_ovf` → `overflow`=0.
- Full with simultaneous push and pop: FIFO full with 1..4, `out_ready`=1 and push 0x0005 in the same cycle → no drop, `count` stays 4, drain order 1, 2, 3, 4, 5.
- Mid-burst reset: FIFO holding 2 entries, assert `rst_n`=0 between clock edges → `out_valid` and `count` go to 0 immediately; after release, the next push of 0x0AAA is the first word out.
